tag_ram_nway: RTL and testbench
===============================

# tag_ram_nway

Parameterised N-way tag store with synchronous read, one-cycle tag compare and hardware valid-bit clearing. It replaces the single-way synchronous-read tag RAM in the cache write-hit-check path. A lookup presents an index and tag and receives per-way hit flags and stored tags one cycle later. Tags are written or invalidated per way. After reset, a built-in sequencer walks every index and clears all valid bits, so no preload file is needed.

## Interface
- AWIDTH, 3: index width; DEPTH = 1 << AWIDTH.
- TWIDTH, 14: tag width.
- WAYS, 2: number of ways (1..8); way selects are one-hot, WAYS bits.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- busy  out  1  high while the clear sequencer runs; lookups and writes are ignored.
- lookup_valid  in  1  lookup request.
- lookup_addr  in  AWIDTH  lookup index.
- lookup_tag  in  TWIDTH  tag to compare.
- result_valid  out  1  lookup result valid (1 cycle after an accepted lookup).
- hit  out  1  OR of hit_way.
- hit_way  out  WAYS  per-way match (valid and tag equal).
- rd_tags  out  WAYS*TWIDTH  stored tags at the looked-up index; way w at bits [w*TWIDTH +: TWIDTH].
- rd_valid  out  WAYS  stored valid bits at the looked-up index.
- wr_en  in  1  write wr_tag into the selected ways and set their valid bits.
- inv_en  in  1  clear valid bits of the selected ways (tags unchanged).
- wr_way  in  WAYS  one-hot or multi-hot way select for wr_en / inv_en.
- wr_addr  in  AWIDTH  write/invalidate index.
- wr_tag  in  TWIDTH  tag data.

## Operation
- Storage:
  - Tags are held in WAYS arrays of DEPTH x TWIDTH with registered read.
  - Valid bits are held in DEPTH x WAYS flops.
- State machine: CLEAR -> READY.
  - reset forces CLEAR, clear counter = 0, busy = 1.
  - CLEAR: each cycle, clear all valid bits at index = counter, then increment. After index DEPTH-1, go to READY. CLEAR lasts exactly DEPTH cycles.
  - READY: busy = 0; lookups, writes and invalidates are accepted.
- Lookup: accepted when lookup_valid && !busy. Index and tag are registered; compare uses the registered tag against the registered read data.
- Write: accepted when wr_en && !busy. For each way w with wr_way[w] = 1, tag[wr_addr] <= wr_tag and valid <= 1. wr_way = 0 is a no-op.
- Invalidate: accepted when inv_en && !busy. The selected valid bits are cleared. If wr_en and inv_en are both high, inv_en wins: the tag is not written and the valid bit is cleared.
- Multiple matching ways (a software error): every matching bit is set in hit_way, and hit = 1. No error flag is raised.
- Lookup and write to the same index in the same cycle: result reflects pre-write contents (read-before-write), unless the bypass macro is defined (see Configuration).
- Writes and invalidates to different indices in the same cycle as a lookup are independent.

## Timing
- Reset values:
  - busy = 1
  - result_valid = 0, hit = 0
  - hit_way = 0, rd_tags = 0, rd_valid = 0
- busy falls in the cycle after the last clear (DEPTH cycles after reset deasserts).
- Lookup latency: 1 cycle. Accepted at edge N; result_valid, hit, hit_way, rd_tags and rd_valid are valid after edge N+1 and held until the next accepted lookup. result_valid is a 1-cycle pulse per accepted lookup.
- Back-to-back lookups every cycle are supported at full throughput.
- Write/invalidate visibility: an update at edge N is visible to a lookup accepted at edge N+1.
- Reset asserted mid-operation: the pending result is dropped (result_valid = 0 after the reset edge) and CLEAR restarts from index 0.

## Configuration
- TAG_RAM_BYPASS_EN defined:
  - A lookup accepted in the same cycle as wr_en or inv_en to the same index returns post-update contents for the selected ways (forwarded tag and valid).
  - Unselected ways return stored contents.
- TAG_RAM_BYPASS_EN undefined: read-before-write; no forwarding logic.

## Test plan
- Reset clear: reset 1 cycle, defaults (AWIDTH=3, WAYS=2) -> busy high exactly 8 cycles; then lookups of all 8 indices return rd_valid = 0 and hit = 0.
- Write then hit: write way 1, addr 5, tag 0x1A2B. Lookup addr 5, tag 0x1A2B -> result_valid 1 cycle later, hit = 1, hit_way = 2'b10, rd_tags[27:14] = 0x1A2B. Lookup with tag 0x1A2C -> hit = 0.
- Invalidate priority: wr_en and inv_en together on way 1, addr 5 -> subsequent lookup gives rd_valid = 2'b00, rd_tags[27:14] still 0x1A2B.
- Same-cycle write/lookup at addr 3, tag 0x0042, way 0 -> without macro hit = 0; with TAG_RAM_BYPASS_EN hit = 1, hit_way = 2'b01.
- Busy gating: write and lookup issued during CLEAR -> no result_valid; after CLEAR, addr targeted by the write reads rd_valid = 0.
- Mid-op reset: lookup accepted, reset on the next edge -> result_valid stays 0, busy = 1 for 8 cycles, all valid bits cleared.

Source files
------------

// File: rtl/tag_ram_nway.sv
// -----------------------------------------------------------------------------
// tag_ram_nway
//
// N-way cache tag store. It has a synchronous (registered) read, a one-cycle tag
// compare and a built-in valid-bit clear sequencer.
//
// A lookup presents an index and a tag. One cycle later it returns:
//   - per-way hit flags
//   - the stored tags at that index
//   - the stored valid bits at that index
//
// Tags are written or invalidated per way (one-hot or multi-hot select).
//
// After reset, a sequencer walks every index and clears all valid bits. This
// takes DEPTH cycles. No preload file is needed.
//
// Optional feature: define TAG_RAM_BYPASS_EN to forward a same-cycle write or
// invalidate (to the looked-up index) into the lookup result. With the macro
// undefined, the result is read-before-write and there is no forwarding logic.
//
// Parameters:
//   AWIDTH  index width, DEPTH = 1 << AWIDTH
//   TWIDTH  tag width
//   WAYS    number of ways (1..8)
//
// Ports:
//   i_clock          single clock, rising edge
//   i_reset          synchronous active-high reset
//   o_busy           high while the clear sequencer runs (requests ignored)
//   i_lookup_valid   lookup request
//   i_lookup_addr    lookup index
//   i_lookup_tag     tag to compare
//   o_result_valid   1-cycle pulse, one cycle after an accepted lookup
//   o_hit            OR of o_hit_way
//   o_hit_way        per-way match (valid and tag equal)
//   o_rd_tags        stored tags, way w at [w*TWIDTH +: TWIDTH]
//   o_rd_valid       stored valid bits
//   i_wr_en          write i_wr_tag into the selected ways, set their valid bits
//   i_inv_en         clear the valid bits of the selected ways (wins over i_wr_en)
//   i_wr_way         way select for write/invalidate
//   i_wr_addr        write/invalidate index
//   i_wr_tag         tag data
// -----------------------------------------------------------------------------
module tag_ram_nway #(
    parameter int AWIDTH = 3,
    parameter int TWIDTH = 14,
    parameter int WAYS   = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    output logic                     o_busy,
    input  logic                     i_lookup_valid,
    input  logic [AWIDTH-1:0]        i_lookup_addr,
    input  logic [TWIDTH-1:0]        i_lookup_tag,
    output logic                     o_result_valid,
    output logic                     o_hit,
    output logic [WAYS-1:0]          o_hit_way,
    output logic [WAYS*TWIDTH-1:0]   o_rd_tags,
    output logic [WAYS-1:0]          o_rd_valid,
    input  logic                     i_wr_en,
    input  logic                     i_inv_en,
    input  logic [WAYS-1:0]          i_wr_way,
    input  logic [AWIDTH-1:0]        i_wr_addr,
    input  logic [TWIDTH-1:0]        i_wr_tag
);

    localparam int DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH-1:0] LAST_IDX = AWIDTH'(DEPTH - 1);

    // State   | meaning
    // --------+----------------------------------------------------------
    // ST_CLEAR| sequencer clears valid bits at r_clr_cnt, requests ignored
    // ST_READY| normal operation, lookups/writes/invalidates accepted
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [AWIDTH-1:0]   r_clr_cnt;
    logic [AWIDTH-1:0]   w_clr_cnt_nxt;
    logic                w_busy;

    logic                w_lk_acc;
    logic                w_wr_acc;
    logic                w_inv_acc;

    logic [WAYS-1:0]     r_valid   [DEPTH];
    logic [TWIDTH-1:0]   r_tag_mem [WAYS][DEPTH];

    logic [WAYS-1:0]     w_fwd_valid;
    logic [TWIDTH-1:0]   w_fwd_tag [WAYS];

    logic                r_result_valid;
    logic [TWIDTH-1:0]   r_cmp_tag;
    logic [WAYS-1:0]     r_rd_valid;
    logic [TWIDTH-1:0]   r_rd_tag [WAYS];
    logic [WAYS-1:0]     w_hit_way;

    // ------------------------------------------------------------------
    // Clear sequencer FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_cnt <= w_clr_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_cnt_nxt = r_clr_cnt;
        w_busy        = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_busy        = 1'b1;
                w_clr_cnt_nxt = r_clr_cnt + 1'b1;
                if (r_clr_cnt == LAST_IDX) begin
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                w_busy = 1'b0;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_busy      = 1'b1;
            end
        endcase
    end

    assign o_busy = w_busy;

    // Nothing is accepted on a reset edge, so a request coinciding with reset
    // cannot leak into the restarted clear sequence.
    assign w_lk_acc  = i_lookup_valid && !w_busy && !i_reset;
    assign w_inv_acc = i_inv_en       && !w_busy && !i_reset;
    assign w_wr_acc  = i_wr_en && !i_inv_en && !w_busy && !i_reset;

    // ------------------------------------------------------------------
    // Valid bits: cleared by the sequencer, else invalidate beats write.
    // The array has no reset; the sequencer is what initialises it.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (!i_reset && (r_state == ST_CLEAR)) begin
            r_valid[r_clr_cnt] <= '0;
        end else if (w_inv_acc) begin
            r_valid[i_wr_addr] <= r_valid[i_wr_addr] & ~i_wr_way;
        end else if (w_wr_acc) begin
            r_valid[i_wr_addr] <= r_valid[i_wr_addr] | i_wr_way;
        end
    end

    // ------------------------------------------------------------------
    // Tag arrays. There is no reset; tags are meaningless until written.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        for (int w = 0; w < WAYS; w++) begin
            if (w_wr_acc && i_wr_way[w]) begin
                r_tag_mem[w][i_wr_addr] <= i_wr_tag;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data selection (with optional same-index forwarding)
    // ------------------------------------------------------------------
    always_comb begin
        w_fwd_valid = r_valid[i_lookup_addr];
        for (int w = 0; w < WAYS; w++) begin
            w_fwd_tag[w] = r_tag_mem[w][i_lookup_addr];
        end
`ifdef TAG_RAM_BYPASS_EN
        if (i_wr_addr == i_lookup_addr) begin
            if (w_inv_acc) begin
                // The tag stays as stored; only the valid bit is forwarded.
                w_fwd_valid = w_fwd_valid & ~i_wr_way;
            end else if (w_wr_acc) begin
                w_fwd_valid = w_fwd_valid | i_wr_way;
                for (int w = 0; w < WAYS; w++) begin
                    if (i_wr_way[w]) begin
                        w_fwd_tag[w] = i_wr_tag;
                    end
                end
            end
        end
`endif
    end

    // ------------------------------------------------------------------
    // Registered read stage. Results are held until the next accepted
    // lookup; only result_valid pulses.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_result_valid <= 1'b0;
            r_cmp_tag      <= '0;
            r_rd_valid     <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_rd_tag[w] <= '0;
            end
        end else begin
            r_result_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_cmp_tag  <= i_lookup_tag;
                r_rd_valid <= w_fwd_valid;
                for (int w = 0; w < WAYS; w++) begin
                    r_rd_tag[w] <= w_fwd_tag[w];
                end
            end
        end
    end

    // Compare sits after the read registers, so a multi-way match simply
    // sets several bits; nothing flags it.
    genvar g;
    generate
        for (g = 0; g < WAYS; g++) begin : g_way
            assign w_hit_way[g] = r_rd_valid[g] && (r_rd_tag[g] == r_cmp_tag);
            assign o_rd_tags[g*TWIDTH +: TWIDTH] = r_rd_tag[g];
        end
    endgenerate

    assign o_result_valid = r_result_valid;
    assign o_hit_way      = w_hit_way;
    assign o_hit          = |w_hit_way;
    assign o_rd_valid     = r_rd_valid;

endmodule

// File: tb/tb_tag_ram_nway.sv
module tb_tag_ram_nway;

    localparam int AW = 3;
    localparam int TW = 14;
    localparam int NW = 2;
    localparam int DP = 1 << AW;

    logic             clk = 1'b0;
    logic             rst;
    logic             busy;
    logic             lk_v;
    logic [AW-1:0]    lk_a;
    logic [TW-1:0]    lk_t;
    logic             res_v;
    logic             hit;
    logic [NW-1:0]    hit_way;
    logic [NW*TW-1:0] rd_tags;
    logic [NW-1:0]    rd_valid;
    logic             wr_en;
    logic             inv_en;
    logic [NW-1:0]    wr_way;
    logic [AW-1:0]    wr_a;
    logic [TW-1:0]    wr_t;

    tag_ram_nway #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(NW)) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .o_busy         (busy),
        .i_lookup_valid (lk_v),
        .i_lookup_addr  (lk_a),
        .i_lookup_tag   (lk_t),
        .o_result_valid (res_v),
        .o_hit          (hit),
        .o_hit_way      (hit_way),
        .o_rd_tags      (rd_tags),
        .o_rd_valid     (rd_valid),
        .i_wr_en        (wr_en),
        .i_inv_en       (inv_en),
        .i_wr_way       (wr_way),
        .i_wr_addr      (wr_a),
        .i_wr_tag       (wr_t)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: contents as plain arrays, busy as cycles left of clearing.
    bit [NW-1:0]  m_valid [DP];
    logic [TW-1:0] m_tag  [NW][DP];
    bit           m_known [NW][DP];
    int           m_clr = 0;

    // Expected (held) outputs.
    bit            e_rv;
    logic [NW-1:0] e_hw;
    logic [NW-1:0] e_rdv;
    logic [TW-1:0] e_tag [NW];
    bit            e_known [NW];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit lk, input int la, input int lt,
                       input bit we, input bit ie, input int way, input int wa, input int wt);
        bit            busy_pre;
        bit            acc_lk, acc_w, acc_i;
        logic [NW-1:0] pv;
        logic [TW-1:0] pt [NW];
        bit            pk [NW];
        logic [NW-1:0] sel;
        sel    = NW'(way);
        rst    = r;
        lk_v   = lk;
        lk_a   = AW'(la);
        lk_t   = TW'(lt);
        wr_en  = we;
        inv_en = ie;
        wr_way = sel;
        wr_a   = AW'(wa);
        wr_t   = TW'(wt);

        busy_pre = (m_clr > 0);
        acc_lk = lk && !busy_pre && !r;
        acc_i  = ie && !busy_pre && !r;
        acc_w  = we && !ie && !busy_pre && !r;

        pv = m_valid[la];
        for (int w = 0; w < NW; w++) begin
            pt[w] = m_tag[w][la];
            pk[w] = m_known[w][la];
        end
`ifdef TAG_RAM_BYPASS_EN
        if (wa == la) begin
            for (int w = 0; w < NW; w++) begin
                if (sel[w] && acc_i) pv[w] = 1'b0;
                else if (sel[w] && acc_w) begin
                    pv[w] = 1'b1;
                    pt[w] = TW'(wt);
                    pk[w] = 1'b1;
                end
            end
        end
`endif

        @(posedge clk);
        #1;

        if (r) begin
            m_clr = DP;
            for (int i = 0; i < DP; i++) m_valid[i] = '0;
            e_rv = 0; e_hw = '0; e_rdv = '0;
            for (int w = 0; w < NW; w++) begin
                e_tag[w] = '0;
                e_known[w] = 1'b1;
            end
        end else begin
            if (busy_pre) m_clr--;
            for (int w = 0; w < NW; w++) begin
                if (sel[w] && acc_i) m_valid[wa][w] = 1'b0;
                else if (sel[w] && acc_w) begin
                    m_valid[wa][w] = 1'b1;
                    m_tag[w][wa]   = TW'(wt);
                    m_known[w][wa] = 1'b1;
                end
            end
            e_rv = acc_lk;
            if (acc_lk) begin
                e_rdv = pv;
                for (int w = 0; w < NW; w++) begin
                    e_tag[w]   = pt[w];
                    e_known[w] = pk[w];
                    e_hw[w]    = pv[w] && pk[w] && (pt[w] == TW'(lt));
                end
            end
        end

        chk("busy", 64'(busy), 64'(m_clr > 0));
        chk("result_valid", 64'(res_v), 64'(e_rv));
        chk("hit_way", 64'(hit_way), 64'(e_hw));
        chk("hit", 64'(hit), 64'(|e_hw));
        chk("rd_valid", 64'(rd_valid), 64'(e_rdv));
        for (int w = 0; w < NW; w++) begin
            if (e_known[w]) chk($sformatf("rd_tag%0d", w), 64'(rd_tags[w*TW +: TW]), 64'(e_tag[w]));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic look(input int la, input int lt);
        cyc(0, 1, la, lt, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int w = 0; w < NW; w++)
            for (int i = 0; i < DP; i++) m_known[w][i] = 1'b0;
        rst = 1'b0; lk_v = 0; lk_a = '0; lk_t = '0;
        wr_en = 0; inv_en = 0; wr_way = '0; wr_a = '0; wr_t = '0;

        // reset defaults, then busy for exactly DP cycles; requests gated meanwhile
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 2, 14'h0077, 1, 0, 2'b01, 2, 14'h0077);
        cyc(0, 1, 2, 14'h0077, 1, 0, 2'b11, 2, 14'h0077);
        idle(DP - 2);
        chk("busy_after_clear", 64'(busy), 64'd0);

        for (int i = 0; i < DP; i++) look(i, 0);

        // write then hit / miss
        cyc(0, 0, 0, 0, 1, 0, 2'b10, 5, 14'h1A2B);
        look(5, 14'h1A2B);
        chk("hit_way_dir", 64'(hit_way), 64'h2);
        look(5, 14'h1A2C);

        // invalidate beats write; tag retained
        cyc(0, 0, 0, 0, 1, 1, 2'b10, 5, 14'h3333);
        look(5, 14'h1A2B);
        chk("inv_tag_kept", 64'(rd_tags[2*TW-1:TW]), 64'h1A2B);

        // same-cycle write/lookup, then the write is visible next cycle
        cyc(0, 1, 3, 14'h0042, 1, 0, 2'b01, 3, 14'h0042);
        look(3, 14'h0042);

        // multi-way write -> multi-hit; back-to-back lookups
        cyc(0, 0, 0, 0, 1, 0, 2'b11, 6, 14'h0555);
        look(6, 14'h0555);
        look(6, 14'h0556);
        look(3, 14'h0042);
        idle(2);

        // mid-operation reset drops the pending result
        look(5, 14'h1A2B);
        cyc(1, 1, 5, 14'h1A2B, 0, 0, 0, 0, 0);
        idle(DP);
        for (int i = 0; i < DP; i++) look(i, 14'h0042);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            bit r;
            r = ($urandom_range(0, 249) == 0);
            cyc(r, $urandom_range(0, 9) < 7, $urandom_range(0, DP - 1),
                14'h100 | $urandom_range(0, 3),
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 1,
                $urandom_range(0, 3), $urandom_range(0, DP - 1),
                14'h100 | $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
